// File: rtl/pico_sim_pkg.sv
// Shared definitions for the PicoBus128 "hello world" register block.
// Holds bus widths, register byte offsets relative to the block base address,
// the default reg1 XOR key, and a small helper that derives a register
// index from its byte offset.
package pico_sim_pkg;

    localparam int PICO_DATA_W = 128;
    localparam int PICO_ADDR_W = 32;
    localparam int NUM_REGS    = 4;

    // Byte offsets of the four registers; each one occupies one 16-byte beat.
    localparam logic [PICO_ADDR_W-1:0] REG0_OFS = 32'h0000_0000;
    localparam logic [PICO_ADDR_W-1:0] REG1_OFS = 32'h0000_0010;
    localparam logic [PICO_ADDR_W-1:0] REG2_OFS = 32'h0000_0020;
    localparam logic [PICO_ADDR_W-1:0] REG3_OFS = 32'h0000_0030;

    localparam logic [PICO_DATA_W-1:0] DEFAULT_XOR_KEY =
        128'hdecafbad_12345678_87654321_deadbeef;

    typedef logic [PICO_DATA_W-1:0] pico_data_t;
    typedef logic [PICO_ADDR_W-1:0] pico_addr_t;

    // Beat index (address bits [31:4]) of a byte offset.
    function automatic logic [PICO_ADDR_W-5:0] beat_index(input pico_addr_t ofs);
        return ofs[PICO_ADDR_W-1:4];
    endfunction

endpackage

// File: rtl/pico_sim_if.sv
// PicoBus128 beat-level bus bundle.
// Signals:
//   PicoAddr    byte address of the current beat (16-byte aligned)
//   PicoDataIn  128-bit write data
//   PicoWr      write strobe, one beat per cycle
//   PicoRd      read strobe, one beat per cycle
//   PicoDataOut 128-bit read data, zero when the slave is not responding
// Modports: master (host bridge side), slave (register block side).
interface pico_sim_if;
    import pico_sim_pkg::*;

    pico_addr_t PicoAddr;
    pico_data_t PicoDataIn;
    logic       PicoWr;
    logic       PicoRd;
    pico_data_t PicoDataOut;

    modport master (
        output PicoAddr,
        output PicoDataIn,
        output PicoWr,
        output PicoRd,
        input  PicoDataOut
    );

    modport slave (
        input  PicoAddr,
        input  PicoDataIn,
        input  PicoWr,
        input  PicoRd,
        output PicoDataOut
    );

endinterface

// File: rtl/pico_sim.sv
// PicoBus128 slave register block.
// Four 128-bit registers on consecutive 16-byte beats starting at BASE_ADDR:
//   +0x00 reg0 stores the inverted write data
//   +0x10 reg1 stores write data XOR XOR_KEY
//   +0x20 reg2 stores write data unchanged
//   +0x30 reg3 read-only 32-bit count of write beats hitting this block
// Reads are registered with one cycle of latency; PicoDataOut is zero in any
// cycle that does not follow a read hit, so several slaves can be OR-ed.
// Ports:
//   PicoClk  clock, all logic on the rising edge
//   PicoRst  synchronous active-high reset
//   bus      pico_sim_if slave modport (address, data, strobes, read data)
module pico_sim
    import pico_sim_pkg::*;
#(
    parameter pico_addr_t BASE_ADDR = 32'h0000_0000,
    parameter pico_data_t XOR_KEY   = DEFAULT_XOR_KEY
) (
    input  logic        PicoClk,
    input  logic        PicoRst,
    pico_sim_if.slave   bus
);

    localparam int IDX_W = PICO_ADDR_W - 4;

    // One-hot decode of which register the current beat addresses. The low
    // address nibble selects a byte inside the beat and is ignored.
    logic [NUM_REGS-1:0] hit;

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_decode
            localparam logic [IDX_W-1:0] REG_IDX =
                beat_index(BASE_ADDR) + IDX_W'(gi);
            assign hit[gi] = (bus.PicoAddr[PICO_ADDR_W-1:4] == REG_IDX);
        end
    endgenerate

    logic unused_addr_bits;
    assign unused_addr_bits = ^bus.PicoAddr[3:0];

    pico_data_t  reg0_reg, reg0_next;
    pico_data_t  reg1_reg, reg1_next;
    pico_data_t  reg2_reg, reg2_next;
    logic [31:0] count_reg, count_next;
    pico_data_t  data_out_reg, data_out_next;

    logic wr_hit;
    assign wr_hit = bus.PicoWr && (|hit);

    always_comb begin
        reg0_next  = reg0_reg;
        reg1_next  = reg1_reg;
        reg2_next  = reg2_reg;
        count_next = count_reg;

        if (bus.PicoWr && hit[0]) reg0_next = ~bus.PicoDataIn;
        if (bus.PicoWr && hit[1]) reg1_next = bus.PicoDataIn ^ XOR_KEY;
        if (bus.PicoWr && hit[2]) reg2_next = bus.PicoDataIn;
        // Writes to reg3 carry no data but still count as a beat.
        if (wr_hit)               count_next = count_reg + 32'd1;
    end

    // Read mux works off the current (pre-write) register values, so a read
    // and write of the same register in one cycle returns the old contents.
    always_comb begin
        data_out_next = '0;
        if (bus.PicoRd) begin
            if (hit[0])      data_out_next = reg0_reg;
            else if (hit[1]) data_out_next = reg1_reg;
            else if (hit[2]) data_out_next = reg2_reg;
            else if (hit[3]) data_out_next = {{(PICO_DATA_W-32){1'b0}}, count_reg};
        end
    end

    always_ff @(posedge PicoClk) begin
        if (PicoRst) begin
            reg0_reg     <= '0;
            reg1_reg     <= '0;
            reg2_reg     <= '0;
            count_reg    <= '0;
            data_out_reg <= '0;
        end else begin
            reg0_reg     <= reg0_next;
            reg1_reg     <= reg1_next;
            reg2_reg     <= reg2_next;
            count_reg    <= count_next;
            data_out_reg <= data_out_next;
        end
    end

    assign bus.PicoDataOut = data_out_reg;

endmodule

// File: tb/tb_pico_sim.sv
// Self-checking bench for pico_sim: directed bring-up sequence, unmapped
// accesses, same-cycle read/write, reset mid-burst, and a randomized phase,
// all compared against a register-level reference model.
module tb_pico_sim;
    import pico_sim_pkg::*;

    localparam pico_data_t KEY  = 128'hdecafbad_12345678_87654321_deadbeef;
    localparam pico_addr_t BASE = 32'h0000_0000;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    pico_sim_if bus();

    pico_sim #(
        .BASE_ADDR (BASE),
        .XOR_KEY   (KEY)
    ) dut (
        .PicoClk (clk),
        .PicoRst (rst),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: stored register contents and the write-beat count.
    pico_data_t  m_reg [3];
    logic [31:0] m_count;

    function automatic int model_idx(input pico_addr_t a);
        longint off;
        off = longint'(a) - longint'(BASE);
        if (off < 0 || off >= 64) return -1;
        return int'(off / 16);
    endfunction

    function automatic pico_data_t model_read(input pico_addr_t a);
        int i;
        i = model_idx(a);
        if (i < 0)  return '0;
        if (i == 3) return pico_data_t'(m_count);
        return m_reg[i];
    endfunction

    task automatic model_write(input pico_addr_t a, input pico_data_t d);
        int i;
        i = model_idx(a);
        if (i < 0) return;
        m_count = m_count + 1;
        case (i)
            0: m_reg[0] = ~d;
            1: m_reg[1] = d ^ KEY;
            2: m_reg[2] = d;
            default: ;
        endcase
    endtask

    task automatic model_reset();
        m_reg[0] = '0;
        m_reg[1] = '0;
        m_reg[2] = '0;
        m_count  = '0;
    endtask

    // Drives one bus beat at the falling edge, returns the DUT output seen
    // just after the following rising edge and the model's expected value.
    task automatic beat(input pico_addr_t a, input pico_data_t d,
                        input logic w, input logic r, input logic rs,
                        output pico_data_t obs, output pico_data_t exp);
        @(negedge clk);
        bus.PicoAddr   = a;
        bus.PicoDataIn = d;
        bus.PicoWr     = w;
        bus.PicoRd     = r;
        rst            = rs;
        if (rs) begin
            exp = '0;
            model_reset();
        end else begin
            exp = r ? model_read(a) : '0;
            if (w) model_write(a, d);
        end
        @(posedge clk);
        #1;
        obs = bus.PicoDataOut;
        $display("beat addr=%h wr=%0d rd=%0d rst=%0d din=%h out=%h", a, w, r, rs, d, obs);
    endtask

    task automatic idle();
        @(negedge clk);
        bus.PicoWr = 1'b0;
        bus.PicoRd = 1'b0;
        rst        = 1'b0;
    endtask

    task automatic test_reset();
        pico_data_t obs, exp;
        beat(32'h0, '0, 1'b0, 1'b0, 1'b1, obs, exp);
        beat(32'h0, '0, 1'b0, 1'b0, 1'b1, obs, exp);
        checks++;
        if (obs !== '0) begin
            $display("FAIL reset_out: got %h want 0", obs);
            errors++;
        end
        for (int i = 0; i < 4; i++) begin
            beat(pico_addr_t'(i * 16), '0, 1'b0, 1'b1, 1'b0, obs, exp);
            checks++;
            if (obs !== '0) begin
                $display("FAIL reset_reg%0d: got %h want 0", i, obs);
                errors++;
            end
        end
    endtask

    task automatic test_write_read();
        pico_data_t obs, exp;
        beat(32'h00, 128'hdeadbeef, 1'b1, 1'b0, 1'b0, obs, exp);
        beat(32'h00, '0, 1'b0, 1'b1, 1'b0, obs, exp);
        checks++;
        if (obs !== ~128'hdeadbeef) begin
            $display("FAIL reg0_invert: got %h want %h", obs, ~128'hdeadbeef);
            errors++;
        end
        // Output must drop back to zero the cycle after a lone read.
        beat(32'h00, '0, 1'b0, 1'b0, 1'b0, obs, exp);
        checks++;
        if (obs !== '0) begin
            $display("FAIL read_release: got %h want 0", obs);
            errors++;
        end
        beat(32'h10, 128'h60, 1'b1, 1'b0, 1'b0, obs, exp);
        beat(32'h20, 128'h60, 1'b1, 1'b0, 1'b0, obs, exp);
        beat(32'h10, '0, 1'b0, 1'b1, 1'b0, obs, exp);
        checks++;
        if (obs !== (KEY ^ 128'h60)) begin
            $display("FAIL reg1_xor: got %h want %h", obs, KEY ^ 128'h60);
            errors++;
        end
        beat(32'h2c, '0, 1'b0, 1'b1, 1'b0, obs, exp);
        checks++;
        if (obs !== 128'h60) begin
            $display("FAIL reg2_plain: got %h want %h", obs, 128'h60);
            errors++;
        end
    endtask

    task automatic test_counter();
        pico_data_t obs, exp;
        beat(32'h30, '0, 1'b0, 1'b1, 1'b0, obs, exp);
        checks++;
        if (obs !== 128'd3) begin
            $display("FAIL count_3: got %h want 3", obs);
            errors++;
        end
        beat(32'h30, 128'h60, 1'b1, 1'b0, 1'b0, obs, exp);
        beat(32'h30, '0, 1'b0, 1'b1, 1'b0, obs, exp);
        checks++;
        if (obs !== 128'd4) begin
            $display("FAIL count_4: got %h want 4", obs);
            errors++;
        end
    endtask

    task automatic test_back_to_back();
        pico_data_t obs, exp;
        pico_data_t want [4];
        want[0] = ~128'hdeadbeef;
        want[1] = KEY ^ 128'h60;
        want[2] = 128'h60;
        want[3] = 128'd4;
        for (int i = 0; i < 4; i++) begin
            beat(pico_addr_t'(i * 16), '0, 1'b0, 1'b1, 1'b0, obs, exp);
            checks++;
            if (obs !== want[i]) begin
                $display("FAIL burst_beat%0d: got %h want %h", i, obs, want[i]);
                errors++;
            end
        end
        beat(32'h0, '0, 1'b0, 1'b0, 1'b0, obs, exp);
        checks++;
        if (obs !== '0) begin
            $display("FAIL burst_release: got %h want 0", obs);
            errors++;
        end
    endtask

    task automatic test_unmapped();
        pico_data_t obs, exp;
        pico_addr_t addrs [2];
        addrs[0] = 32'h40;
        addrs[1] = 32'h1000;
        for (int i = 0; i < 2; i++) begin
            beat(addrs[i], 128'h1234, 1'b1, 1'b0, 1'b0, obs, exp);
            beat(addrs[i], '0, 1'b0, 1'b1, 1'b0, obs, exp);
            checks++;
            if (obs !== '0) begin
                $display("FAIL unmapped_%h: got %h want 0", addrs[i], obs);
                errors++;
            end
        end
        beat(32'h30, '0, 1'b0, 1'b1, 1'b0, obs, exp);
        checks++;
        if (obs !== 128'd4) begin
            $display("FAIL unmapped_count: got %h want 4", obs);
            errors++;
        end
    endtask

    task automatic test_same_cycle();
        pico_data_t obs, exp;
        beat(32'h20, 128'habcd, 1'b1, 1'b1, 1'b0, obs, exp);
        checks++;
        if (obs !== 128'h60) begin
            $display("FAIL rw_same_old: got %h want %h", obs, 128'h60);
            errors++;
        end
        beat(32'h30, 128'h0, 1'b1, 1'b1, 1'b0, obs, exp);
        checks++;
        if (obs !== 128'd5) begin
            $display("FAIL rw_count_old: got %h want 5", obs);
            errors++;
        end
        beat(32'h20, '0, 1'b0, 1'b1, 1'b0, obs, exp);
        checks++;
        if (obs !== 128'habcd) begin
            $display("FAIL rw_same_new: got %h want %h", obs, 128'habcd);
            errors++;
        end
    endtask

    task automatic test_reset_mid_burst();
        pico_data_t obs, exp;
        beat(32'h00, '0, 1'b0, 1'b1, 1'b0, obs, exp);
        beat(32'h10, '0, 1'b0, 1'b1, 1'b0, obs, exp);
        beat(32'h20, 128'h77, 1'b1, 1'b1, 1'b1, obs, exp);
        checks++;
        if (obs !== '0) begin
            $display("FAIL rst_burst_out: got %h want 0", obs);
            errors++;
        end
        for (int i = 0; i < 4; i++) begin
            beat(pico_addr_t'(i * 16), '0, 1'b0, 1'b1, 1'b0, obs, exp);
            checks++;
            if (obs !== '0) begin
                $display("FAIL rst_burst_reg%0d: got %h want 0", i, obs);
                errors++;
            end
        end
    endtask

    task automatic test_random();
        pico_data_t obs, exp, d;
        pico_addr_t a;
        logic w, r;
        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 5))
                0, 1, 2, 3: a = BASE + pico_addr_t'($urandom_range(0, 3) * 16);
                4:          a = BASE + 32'h40;
                default:    a = $urandom;
            endcase
            a[3:0] = 4'($urandom);
            d = {$urandom, $urandom, $urandom, $urandom};
            w = 1'($urandom);
            r = 1'($urandom);
            beat(a, d, w, r, 1'b0, obs, exp);
            checks++;
            if (obs !== exp) begin
                $display("FAIL random_%0d: got %h want %h", n, obs, exp);
                errors++;
            end
        end
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        rst            = 1'b1;
        bus.PicoAddr   = '0;
        bus.PicoDataIn = '0;
        bus.PicoWr     = 1'b0;
        bus.PicoRd     = 1'b0;
        model_reset();

        test_reset();
        test_write_read();
        test_counter();
        test_back_to_back();
        test_unmapped();
        test_same_cycle();
        test_reset_mid_burst();
        test_random();
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
